fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Shares the write port of one sync_fifo between NREQ requesters.
//   Round-robin arbitration at packet granularity.
//   A granted requester keeps the FIFO write port until its last beat or until MAX_BURST beats.
//   Sits directly in front of sync_fifo; its fifo_* outputs connect to sync_fifo din/wr_en/full.
// PARAMETERS
//   NREQ      = 4  number of requesters (>=2)
//   DSIZE     = 8  data width; must match the downstream sync_fifo DSIZE
//   MAX_BURST = 4  maximum beats per grant (>=1); forces release even when last is not seen
// PORTS
//   clk         in   1            clock; all logic on posedge
//   rst_b       in   1            synchronous reset, active-low
//   req_valid   in   NREQ         per-requester beat valid
//   req_data    in   NREQ*DSIZE   per-requester beat data; requester i uses bits [i*DSIZE +: DSIZE]
//   req_last    in   NREQ         per-requester beat is the final beat of its packet
//   req_ready   out  NREQ         per-requester beat accepted this cycle (one-hot or zero)
//   fifo_din    out  DSIZE        data to sync_fifo din
//   fifo_wr_en  out  1            write strobe to sync_fifo
//   fifo_full   in   1            full flag from sync_fifo
//   grant_id    out  $clog2(NREQ) requester currently owning the port (valid when busy=1)
//   busy        out  1            a grant is active (state XFER)
// BEHAVIOUR
//   Reset (rst_b=0 at posedge):
//     state=IDLE; grant_id=0; last_grant=NREQ-1, so requester 0 has top priority first.
//     beat_cnt=0; busy=0; req_ready=0; fifo_wr_en=0.
//   Reset mid-packet: the packet is abandoned.
//     No further beats are written; the requester must restart after reset.
//   FSM states are IDLE and XFER.
//   IDLE:
//     If any req_valid is high, pick the first valid requester after last_grant
//     (search last_grant+1 ... wrapping mod NREQ).
//     Register the pick into grant_id, clear beat_cnt, go to XFER.
//     No beat is transferred in IDLE, so arbitration costs 1 cycle.
//   XFER, combinational outputs:
//     accept = req_valid[grant_id] & ~fifo_full
//     fifo_wr_en = accept
//     req_ready[grant_id] = accept; all other req_ready bits are 0
//     fifo_din = req_data[grant_id]
//   XFER, on each accept:
//     beat_cnt increments.
//     If req_last[grant_id]=1 or beat_cnt==MAX_BURST-1: last_grant<=grant_id, beat_cnt<=0, go to IDLE.
//   XFER holds without changing state when:
//     the owner drops valid (stall); no timeout exists.
//     fifo_full=1 (back-pressure); fifo_wr_en is never asserted while fifo_full=1.
//   In IDLE, fifo_din = req_data[grant_id]; it is don't-care because fifo_wr_en=0.
//   Simultaneous events:
//     A last beat accepted in the same cycle fifo_full rises is a legal write;
//     full is sampled combinationally, pre-write.
//     Other requesters asserting valid during XFER wait.
//     Rotation guarantees each waiting requester a grant within NREQ-1 packets.
//   Widths:
//     beat_cnt is $clog2(MAX_BURST+1) bits.
//     The pointer wrap uses mod-NREQ compare, not power-of-two overflow, so non-power-of-two NREQ is legal.
// STRUCTURE
//   Package fifo_arb_pkg:
//     typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t
//     function rr_next(req, last) returning the next grant index
//   Sub-module rr_pick (combinational):
//     inputs req[NREQ], last[$clog2(NREQ)]; outputs idx, any
//     reused by the future read-side scheduler
//   Top module: FSM, beat_cnt, last_grant register, output muxing.
// TESTING  (NREQ=4, DSIZE=8, MAX_BURST=4, sync_fifo ASIZE=3 attached)
//   1 Reset then valid on req0 and req2, each a 2-beat packet:
//     req0 granted at cycle 1, beats written at cycles 1-2; IDLE; req2 granted; FIFO reads back in req0, req2 order.
//   2 All 4 requesters continuously valid with 1-beat packets:
//     grant order 0,1,2,3,0; one write every 2 cycles.
//   3 req1 sends 6 beats with last only on beat 6:
//     release after beat 4; others idle, so req1 is re-granted and beats 5-6 are written; no data lost or reordered.
//   4 Fill the FIFO to full (8 entries) mid-packet:
//     fifo_wr_en=0 and req_ready=0 while full; one FIFO read releases exactly one beat.
//   5 Owner drops valid for 3 cycles mid-packet while req3 is valid:
//     grant is held; req3 is not served until the owner's last beat.
//   6 Assert rst_b=0 for 1 cycle mid-XFER:
//     next cycle busy=0, req_ready=0, fifo_wr_en=0; the next grant goes to req0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and related schedulers.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;

  // Widest request vector rr_next can search.
  localparam int unsigned MaxReq = 32;

  // Round-robin search: first set bit of req strictly after 'last', wrapping mod nreq.
  // Wrap is an explicit compare so nreq need not be a power of two.
  // Returns 'last' when no request is set.
  function automatic int unsigned rr_next(input logic [MaxReq-1:0] req,
                                          input int unsigned       last,
                                          input int unsigned       nreq);
    int unsigned cand;
    int unsigned pick;
    logic        found;
    cand  = last;
    pick  = last;
    found = 1'b0;
    for (int k = 0; k < int'(MaxReq); k++) begin
      if (k < int'(nreq)) begin
        cand = (cand + 1 >= nreq) ? 0 : cand + 1;
        if (!found && req[cand[4:0]]) begin
          pick  = cand;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: next requester after 'last' with req set.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [MaxReq-1:0] req_ext;

  // Zero-extend the request vector and run the shared search.
  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    idx                = IW'(rr_next(req_ext, 32'(last), NREQ));
    any                = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-granular arbiter sharing one sync_fifo write port among NREQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic [DSIZE-1:0]        fifo_din,
  output logic                    fifo_wr_en,
  input  logic                    fifo_full,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_t     state_q;
  logic [IW-1:0]  grant_q;
  logic [IW-1:0]  last_q;
  logic [CW-1:0]  beat_cnt_q;
  logic [IW-1:0]  pick_idx;
  logic           pick_any;
  logic           accept;
  logic           burst_end;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req  (req_valid),
    .last (last_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Beat handshake: full is sampled pre-write, so a write never happens while full.
  always_comb begin
    accept    = (state_q == ARB_XFER) & req_valid[grant_q] & ~fifo_full;
    burst_end = req_last[grant_q] | (beat_cnt_q == CW'(MAX_BURST - 1));
    req_ready = '0;
    if (accept) req_ready[grant_q] = 1'b1;
    fifo_wr_en = accept;
    fifo_din   = req_data[grant_q*DSIZE +: DSIZE];
    grant_id   = grant_q;
    busy       = (state_q == ARB_XFER);
  end

  // Grant FSM: arbitrate in IDLE, move beats in XFER until last beat or burst limit.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      last_q     <= IW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (accept) begin
            if (burst_end) begin
              last_q     <= grant_q;
              beat_cnt_q <= '0;
              state_q    <= ARB_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a depth-8 FIFO model attached.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_b;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(
    .NREQ      (4),
    .DSIZE     (8),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Depth-8 FIFO model standing in for sync_fifo.
  logic [7:0]  fmem [8];
  int unsigned fwp  = 0;
  int unsigned frp  = 0;
  int unsigned fcnt = 0;
  logic        frd  = 1'b0;

  assign fifo_full = (fcnt == 8);

  always @(posedge clk) begin
    if (fifo_wr_en && fcnt < 8) begin
      fmem[fwp] <= fifo_din;
      fwp       <= (fwp + 1) % 8;
    end
    if (frd && fcnt > 0) frp <= (frp + 1) % 8;
    fcnt <= fcnt + ((fifo_wr_en && fcnt < 8) ? 1 : 0) - ((frd && fcnt > 0) ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One XFER cycle in which requester r must have beat d accepted.
  task automatic send_beat(input int r, input logic [7:0] d, input logic l);
    req_valid[r]       = 1'b1;
    req_data[r*8 +: 8] = d;
    req_last[r]        = l;
    @(negedge clk);
    check("beat_busy", 32'(busy), 1);
    check("beat_grant", 32'(grant_id), r);
    check("beat_wr_en", 32'(fifo_wr_en), 1);
    check("beat_ready", 32'(req_ready), 32'(1) << r);
    check("beat_din", 32'(fifo_din), 32'(d));
    tick();
  endtask

  // One cycle in which nothing may be written and no grant is active.
  task automatic idle_cycle;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_wr_en", 32'(fifo_wr_en), 0);
    check("idle_ready", 32'(req_ready), 0);
    tick();
  endtask

  // Grant held but no beat may move (stall or back-pressure).
  task automatic hold_cycle(input int r);
    @(negedge clk);
    check("hold_busy", 32'(busy), 1);
    check("hold_grant", 32'(grant_id), r);
    check("hold_wr_en", 32'(fifo_wr_en), 0);
    check("hold_ready", 32'(req_ready), 0);
    tick();
  endtask

  task automatic pop(input logic [7:0] e);
    check("fifo_nonempty", 32'(fcnt != 0), 1);
    check("fifo_data", 32'(fmem[frp]), 32'(e));
    frd = 1'b1;
    tick();
    frd = 1'b0;
  endtask

  task automatic do_reset;
    rst_b     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_b = 1'b1;
  endtask

  initial begin
    rst_b     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    // Reset state.
    do_reset();
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    tick();

    // Two 2-beat packets from req0 and req2; req0 wins first.
    req_valid = 4'b0101;
    idle_cycle();
    send_beat(0, 8'hA0, 1'b0);
    send_beat(0, 8'hA1, 1'b1);
    req_valid[0] = 1'b0;
    idle_cycle();
    send_beat(2, 8'hC0, 1'b0);
    send_beat(2, 8'hC1, 1'b1);
    req_valid = '0;
    idle_cycle();
    check("t1_count", fcnt, 4);
    pop(8'hA0);
    pop(8'hA1);
    pop(8'hC0);
    pop(8'hC1);

    // All four valid with 1-beat packets: grants 0,1,2,3,0, one write per 2 cycles.
    do_reset();
    req_data = 32'h1312_1110;
    req_last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b1111;
      idle_cycle();
      send_beat(k % 4, 8'h10 + 8'(k % 4), 1'b1);
    end
    req_valid = '0;
    req_last  = '0;
    tick();
    check("t2_count", fcnt, 5);
    pop(8'h10);
    pop(8'h11);
    pop(8'h12);
    pop(8'h13);
    pop(8'h10);

    // req1 sends 6 beats: forced release after beat 4, then re-granted.
    req_valid = 4'b0010;
    idle_cycle();
    for (int b = 0; b < 6; b++) begin
      if (b == 4) idle_cycle();
      send_beat(1, 8'h30 + 8'(b), (b == 5) ? 1'b1 : 1'b0);
    end
    req_valid = '0;
    idle_cycle();
    for (int b = 0; b < 6; b++) pop(8'h30 + 8'(b));

    // req2 fills the FIFO mid-packet; each read releases exactly one beat.
    req_valid = 4'b0100;
    req_last  = '0;
    idle_cycle();
    for (int b = 0; b < 8; b++) begin
      if (b == 4) idle_cycle();
      send_beat(2, 8'h40 + 8'(b), 1'b0);
    end
    idle_cycle();
    check("t4_full", 32'(fifo_full), 1);
    req_data[23:16] = 8'h48;
    hold_cycle(2);
    hold_cycle(2);
    check("fifo_data", 32'(fmem[frp]), 32'h40);
    frd = 1'b1;
    hold_cycle(2);
    frd = 1'b0;
    send_beat(2, 8'h48, 1'b0);
    check("t4_refull", 32'(fifo_full), 1);
    req_data[23:16] = 8'h49;
    req_last[2]     = 1'b1;
    hold_cycle(2);
    check("fifo_data", 32'(fmem[frp]), 32'h41);
    frd = 1'b1;
    hold_cycle(2);
    frd = 1'b0;
    send_beat(2, 8'h49, 1'b1);
    req_valid = '0;
    req_last  = '0;
    idle_cycle();
    for (int b = 2; b < 10; b++) pop(8'h40 + 8'(b));
    check("t4_empty", fcnt, 0);

    // Owner req0 stalls 3 cycles while req3 waits; grant is held.
    req_valid = 4'b0001;
    idle_cycle();
    req_valid[3]    = 1'b1;
    req_data[31:24] = 8'h60;
    req_last[3]     = 1'b1;
    send_beat(0, 8'h50, 1'b0);
    req_valid[0] = 1'b0;
    hold_cycle(0);
    hold_cycle(0);
    hold_cycle(0);
    send_beat(0, 8'h51, 1'b1);
    req_valid[0] = 1'b0;
    idle_cycle();
    send_beat(3, 8'h60, 1'b1);
    req_valid = '0;
    req_last  = '0;
    idle_cycle();
    pop(8'h50);
    pop(8'h51);
    pop(8'h60);

    // Reset for one cycle mid-XFER; the next grant goes to req0.
    req_valid = 4'b0010;
    idle_cycle();
    send_beat(1, 8'h70, 1'b0);
    rst_b     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("t6_rst_cycle_wr_en", 32'(fifo_wr_en), 0);
    tick();
    rst_b     = 1'b1;
    req_valid = 4'b0011;
    @(negedge clk);
    check("t6_busy", 32'(busy), 0);
    check("t6_ready", 32'(req_ready), 0);
    check("t6_wr_en", 32'(fifo_wr_en), 0);
    tick();
    send_beat(0, 8'h80, 1'b1);
    req_valid = '0;
    idle_cycle();
    pop(8'h70);
    pop(8'h80);
    check("t6_empty", fcnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
